riga_receiver: RTL and testbench

// Consumer end of the dav_/rfd line handshake. Accepts 24-bit ASCII records "k:v".

---
 rtl/riga_receiver.sv | 115 +++++++++++
 tb/tb_riga_receiver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riga_receiver.sv
// rtl/riga_receiver.sv - consumer side of the dav_/rfd handshake for "k:v" ASCII records
// Captures one record per transfer, validates it and stores the value at its index.
module riga_receiver #(
  parameter int N_ENT = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dav_,
  output logic             rfd,
  input  logic [23:0]      riga,
  input  logic [3:0]       rd_addr,
  output logic [3:0]       rd_data,
  output logic [N_ENT-1:0] valid,
  output logic             done,
  output logic [CNT_W-1:0] rec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0]       N_ENT_L = 4'(N_ENT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [23:0]        rbuf_q, rbuf_d;
  logic [3:0]         tbl_q [N_ENT];
  logic [3:0]         tbl_d [N_ENT];
  logic [N_ENT-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]   rec_q, rec_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic               well_formed;
  logic [3:0]         rec_k;
  logic [3:0]         rec_v;

  assign rec_k = rbuf_q[19:16];
  assign rec_v = rbuf_q[3:0];
  // Value char must be 0x30..0x3F, so 0x3A..0x3F carry values 10..15.
  assign well_formed = (rbuf_q[23:20] == 4'h3) && (rec_k < N_ENT_L) &&
                       (rbuf_q[15:8] == 8'h3A) && (rbuf_q[7:4] == 4'h3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rbuf_q  <= '0;
      valid_q <= '0;
      rec_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < N_ENT; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      valid_q <= valid_d;
      rec_q   <= rec_d;
      err_q   <= err_d;
      for (int i = 0; i < N_ENT; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    valid_d = valid_q;
    rec_d   = rec_q;
    err_d   = err_q;
    for (int i = 0; i < N_ENT; i++) tbl_d[i] = tbl_q[i];
    case (state_q)
      S_IDLE: begin
        if (!dav_) begin
          rbuf_d  = riga;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (well_formed) begin
          for (int i = 0; i < N_ENT; i++) begin
            if (rec_k == 4'(i)) begin
              tbl_d[i]   = rec_v;
              valid_d[i] = 1'b1;
            end
          end
          if (rec_q != CNT_MAX) rec_d = rec_q + CNT_ONE;
        end else if (err_q != CNT_MAX) begin
          err_d = err_q + CNT_ONE;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dav_) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rfd decodes straight from the state so reset raises it without a clock edge.
  assign rfd     = (state_q == S_IDLE);
  assign valid   = valid_q;
  assign done    = &valid_q;
  assign rec_cnt = rec_q;
  assign err_cnt = err_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (rd_addr == 4'(i)) rd_data = tbl_q[i];
    end
  end

endmodule

// File: tb/tb_riga_receiver.sv
// tb/tb_riga_receiver.sv - scoreboard bench for riga_receiver
// Driver pushes the expected state per transfer; monitor checks it when rfd returns high.
module tb_riga_receiver;
  localparam int N_ENT = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             dav_;
  logic             rfd;
  logic [23:0]      riga;
  logic [3:0]       rd_addr;
  logic [3:0]       rd_data;
  logic [N_ENT-1:0] valid;
  logic             done;
  logic [CNT_W-1:0] rec_cnt;
  logic [CNT_W-1:0] err_cnt;

  riga_receiver #(.N_ENT(N_ENT), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .dav_    (dav_),
    .rfd     (rfd),
    .riga    (riga),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .valid   (valid),
    .done    (done),
    .rec_cnt (rec_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] valid;
    logic [3:0] rec;
    logic [3:0] err;
    logic [3:0] rd;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3:0] m_tbl [N_ENT];
  logic [7:0] m_valid;
  logic [3:0] m_rec;
  logic [3:0] m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) m_tbl[i] = 4'h0;
    m_valid = '0;
    m_rec   = '0;
    m_err   = '0;
  endtask

  task automatic model_update(input logic [23:0] rec);
    logic wf;
    wf = (rec[23:20] == 4'h3) && (rec[19:16] < 4'd8) && (rec[15:8] == 8'h3A) && (rec[7:4] == 4'h3);
    if (wf) begin
      m_tbl[rec[18:16]]   = rec[3:0];
      m_valid[rec[18:16]] = 1'b1;
      if (m_rec != 4'hF) m_rec = m_rec + 4'd1;
    end else if (m_err != 4'hF) begin
      m_err = m_err + 4'd1;
    end
  endtask

  function automatic exp_t make_exp(input logic [3:0] raddr);
    exp_t e;
    e.valid = m_valid;
    e.rec   = m_rec;
    e.err   = m_err;
    e.rd    = (raddr < 4'd8) ? m_tbl[raddr[2:0]] : 4'h0;
    e.done  = &m_valid;
    return e;
  endfunction

  // Monitor: a completed handshake shows as rfd rising outside reset.
  logic rfd_prev = 1'b1;
  exp_t mon_e;
  always @(negedge clock) begin
    if (!reset && rfd && !rfd_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_completion", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_valid",   32'(valid),   32'(mon_e.valid));
        chk("sb_rec_cnt", 32'(rec_cnt), 32'(mon_e.rec));
        chk("sb_err_cnt", 32'(err_cnt), 32'(mon_e.err));
        chk("sb_rd_data", 32'(rd_data), 32'(mon_e.rd));
        chk("sb_done",    32'(done),    32'(mon_e.done));
      end
    end
    rfd_prev = rfd;
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [23:0] rec, input logic [3:0] raddr,
                      input int hold, input logic [23:0] alt);
    logic [7:0] v0;
    logic [3:0] r0;
    logic [3:0] e0;
    v0 = m_valid;
    r0 = m_rec;
    e0 = m_err;
    model_update(rec);
    exp_q.push_back(make_exp(raddr));
    @(negedge clock);
    riga    = rec;
    dav_    = 1'b0;
    rd_addr = raddr;
    @(posedge clock); #1;
    chk("rfd_fall_edge1", 32'(rfd), 32'd0);
    chk("valid_edge1", 32'(valid), 32'(v0));
    chk("rec_edge1", 32'(rec_cnt), 32'(r0));
    chk("err_edge1", 32'(err_cnt), 32'(e0));
    @(posedge clock); #1;
    chk("valid_edge2", 32'(valid), 32'(m_valid));
    chk("rec_edge2", 32'(rec_cnt), 32'(m_rec));
    chk("err_edge2", 32'(err_cnt), 32'(m_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (i == hold / 2) riga = alt;
      chk("rfd_hold_low", 32'(rfd), 32'd0);
    end
    @(negedge clock);
    dav_ = 1'b1;
    @(posedge clock); #1;
    chk("rfd_rise", 32'(rfd), 32'd1);
    @(negedge clock); #1;
  endtask

  initial begin
    reset   = 1'b1;
    dav_    = 1'b1;
    riga    = 24'h0;
    rd_addr = 4'h0;
    model_reset();

    // Reset values
    #2;
    chk("rst_rfd", 32'(rfd), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rec", 32'(rec_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    do_reset();

    // 1: single record "3:5"
    send(24'h333A35, 4'd3, 0, 24'h0);
    chk("t1_valid", 32'(valid), 32'h08);
    chk("t1_table3", 32'(rd_data), 32'h5);

    // 2: sweep all indices with v = k ^ 0xA
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send({4'h3, 4'(k), 8'h3A, 4'h3, 4'(k) ^ 4'hA}, 4'(k), 0, 24'h0);
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_rec", 32'(rec_cnt), 32'd8);
    chk("t2_err", 32'(err_cnt), 32'd0);
    rd_addr = 4'd7; #1;
    chk("t2_rd7", 32'(rd_data), 32'hD);
    rd_addr = 4'd9; #1;
    chk("t2_rd9", 32'(rd_data), 32'h0);

    // 3: malformed records
    send(24'h383A31, 4'd0, 0, 24'h0);
    send(24'h322D31, 4'd2, 0, 24'h0);
    send(24'h333A45, 4'd3, 0, 24'h0);
    chk("t3_err", 32'(err_cnt), 32'd3);
    chk("t3_valid", 32'(valid), 32'hFF);

    // 4: dav_ held low 20 cycles, riga changed mid-hold
    send(24'h353A37, 4'd5, 20, 24'h313A32);
    chk("t4_rec", 32'(rec_cnt), 32'd9);
    rd_addr = 4'd1; #1;
    chk("t4_table1_untouched", 32'(rd_data), 32'hB);
    rd_addr = 4'd5; #1;
    chk("t4_table5", 32'(rd_data), 32'h7);

    // 5: overwrite then saturate
    do_reset();
    send(24'h323A31, 4'd2, 0, 24'h0);
    send(24'h323A3F, 4'd2, 0, 24'h0);
    chk("t5_table2", 32'(rd_data), 32'hF);
    chk("t5_rec2", 32'(rec_cnt), 32'd2);
    chk("t5_valid", 32'(valid), 32'h04);
    for (int i = 0; i < 20; i++) begin
      send({4'h3, 4'(i % 8), 8'h3A, 4'h3, 4'(i % 16)}, 4'(i % 8), 0, 24'h0);
    end
    chk("t5_rec_sat", 32'(rec_cnt), 32'd15);

    // 6: asynchronous reset during CHECK, dav_ still low on release
    @(negedge clock);
    riga    = 24'h363A32;
    dav_    = 1'b0;
    rd_addr = 4'd6;
    @(posedge clock); #1;
    chk("t6_rfd_low", 32'(rfd), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_rfd", 32'(rfd), 32'd1);
    chk("t6_async_valid", 32'(valid), 32'd0);
    chk("t6_async_rec", 32'(rec_cnt), 32'd0);
    chk("t6_async_err", 32'(err_cnt), 32'd0);
    model_reset();
    model_update(24'h363A32);
    exp_q.push_back(make_exp(4'd6));
    @(negedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("t6_recapture", 32'(rfd), 32'd0);
    @(posedge clock); #1;
    chk("t6_rec", 32'(rec_cnt), 32'd1);
    @(negedge clock);
    dav_ = 1'b1;
    @(posedge clock); #1;
    chk("t6_rfd_rise", 32'(rfd), 32'd1);
    @(negedge clock); #1;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
